fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, 8, data word width in bits.
REQ-002 Parameter BURST_LEN, 4, words read per start command (legal range 1..255).
REQ-003 Parameter TIMEOUT, 64, maximum consecutive empty cycles tolerated in REQ (used only with the macro in REQ-024).
REQ-004 Port rd_clk_i, input, 1, the block's single clock; all logic is on its rising edge.
REQ-005 Port rst_i, input, 1, reset, asynchronous and active-high.
REQ-006 Port start_i, input, 1, single-cycle burst request, sampled only in IDLE.
REQ-007 Port fifo_empty_i, input, 1, FIFO empty flag.
REQ-008 Port fifo_rdata_i, input, WIDTH, FIFO read data, valid the cycle after fifo_rd_en_o.
REQ-009 Port fifo_error_i, input, 1, FIFO underflow/overflow error flag.
REQ-010 Port fifo_rd_en_o, output, 1, FIFO read strobe.
REQ-011 Port m_valid_o / m_data_o / m_ready_i, output 1 / output WIDTH / input 1, downstream valid-ready stream.
REQ-012 Port busy_o, done_o, err_o, count_o, outputs of 1, 1, 1 and 8 bits: burst active; one-cycle completion pulse; sticky error; words delivered in the current burst.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, CAPT, SEND and DONE; busy_o=1 in every state except IDLE.
REQ-014 IDLE: start_i=1 -> REQ and count_o cleared to 0; otherwise hold.
REQ-015 REQ: fifo_empty_i=0 -> fifo_rd_en_o=1 for exactly this one cycle, then CAPT; fifo_empty_i=1 -> fifo_rd_en_o=0 and stay in REQ.
REQ-016 CAPT: register fifo_rdata_i into m_data_o, set m_valid_o=1, go to SEND. Read latency is 2 cycles from the fifo_rd_en_o cycle to the first m_valid_o cycle.
REQ-017 CAPT: fifo_error_i=1 -> set err_o=1; the word is still forwarded.
REQ-018 SEND: m_valid_o and m_data_o SHALL stay stable until m_ready_i=1. On handshake, count_o increments by 1 and m_valid_o drops the next cycle; go to DONE if the new count equals BURST_LEN, else to REQ.
REQ-019 DONE: done_o=1 for one cycle, then IDLE.
REQ-020 fifo_rd_en_o SHALL never be asserted while fifo_empty_i=1, or in any state other than REQ.
REQ-021 start_i outside IDLE is ignored. err_o clears only on reset or on an accepted start_i.
REQ-022 BURST_LEN=1: one read, then DONE immediately after the first handshake.

Reset
REQ-023 rst_i=1, at any time including mid-burst, SHALL immediately force IDLE and drive fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, busy_o=0, done_o=0, err_o=0, count_o=0; an interrupted burst is abandoned without resumption.

Configuration
REQ-024 Macro FIFO_READER_TIMEOUT_EN defined: an 8-bit empty-cycle counter runs in REQ and clears when leaving REQ. When it reaches TIMEOUT, the FSM sets err_o=1 and goes to DONE, with done_o pulsing as normal. Undefined: no counter exists and REQ waits indefinitely.

Structure
REQ-025 The FSM state enum and the 8-bit count width constant SHALL live in the shared package fifo_pkg.
REQ-026 The block is a single module without sub-modules; the timeout counter is inline logic under the macro.

Verification
REQ-027 Non-empty FIFO holding 0x11,0x22,0x33,0x44; start_i pulse; m_ready_i=1 -> four beats 0x11..0x44 in order, done_o pulses once, count_o=4.
REQ-028 m_ready_i held 0 for 5 cycles in SEND -> m_data_o and m_valid_o remain unchanged, no fifo_rd_en_o, count_o does not advance.
REQ-029 fifo_empty_i=1 for 10 cycles in REQ, then 0 -> fifo_rd_en_o stays 0 during the 10 cycles, then a single pulse; the burst completes correctly.
REQ-030 fifo_error_i=1 in CAPT -> err_o=1 and stays set through DONE into IDLE, and clears on the next start_i.
REQ-031 rst_i asserted for 1 cycle during SEND with count_o=2 -> all outputs are at reset values within that cycle; a new start_i performs a full BURST_LEN burst.
REQ-032 With FIFO_READER_TIMEOUT_EN and TIMEOUT=64, FIFO always empty -> err_o=1 and done_o pulses after 64 REQ cycles; without the macro, no done_o within 200 cycles.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst reader.
package fifo_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// Bundle of FIFO-side, stream-side and status signals of fifo_reader.
interface fifo_reader_if #(
  parameter int unsigned WIDTH = 8
);

  logic                         start_i;
  logic                         fifo_empty_i;
  logic [WIDTH-1:0]             fifo_rdata_i;
  logic                         fifo_error_i;
  logic                         fifo_rd_en_o;
  logic                         m_valid_o;
  logic [WIDTH-1:0]             m_data_o;
  logic                         m_ready_i;
  logic                         busy_o;
  logic                         done_o;
  logic                         err_o;
  logic [fifo_pkg::COUNT_W-1:0] count_o;

  // Reader side
  modport master (
    input  start_i, fifo_empty_i, fifo_rdata_i, fifo_error_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, busy_o, done_o, err_o, count_o
  );

  // Environment side (FIFO, requester, downstream sink)
  modport slave (
    output start_i, fifo_empty_i, fifo_rdata_i, fifo_error_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, busy_o, done_o, err_o, count_o
  );

endinterface

// File: rtl/fifo_reader.sv
// Reads BURST_LEN words from a FIFO per start command and forwards them on a valid/ready stream.
// Optional macro FIFO_READER_TIMEOUT_EN aborts a burst after TIMEOUT consecutive empty cycles.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic           rd_clk_i,
  input logic           rst_i,
  fifo_reader_if.master bus
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("fifo_reader: BURST_LEN and TIMEOUT must be within 1..255");
  end

  state_t               state, next_state;
  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 handshake;
  logic                 timeout_hit;

  assign handshake = (state == SEND) && bus.m_ready_i;

`ifdef FIFO_READER_TIMEOUT_EN
  localparam logic [COUNT_W-1:0] TMO_LAST = COUNT_W'(TIMEOUT - 1);

  logic [COUNT_W-1:0] tmo_cnt;

  // Consecutive empty cycles spent waiting in REQ
  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (state == REQ && bus.fifo_empty_i) begin
      tmo_cnt <= tmo_cnt + COUNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeout_hit = (state == REQ) && bus.fifo_empty_i && (tmo_cnt == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.start_i) next_state = REQ;
      REQ: begin
        if (!bus.fifo_empty_i) begin
          next_state = CAPT;
        end else if (timeout_hit) begin
          next_state = DONE;
        end
      end
      CAPT: next_state = SEND;
      SEND: begin
        if (bus.m_ready_i) begin
          next_state = ((count_q + COUNT_W'(1)) == LAST_COUNT) ? DONE : REQ;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
    if (state == IDLE && bus.start_i) begin
      count_d = '0;
      err_d   = 1'b0;
    end
    if (state == CAPT) begin
      valid_d = 1'b1;
      data_d  = bus.fifo_rdata_i;
      if (bus.fifo_error_i) err_d = 1'b1;
    end
    if (handshake) begin
      valid_d = 1'b0;
      count_d = count_q + COUNT_W'(1);
    end
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read strobe must coincide with the REQ cycle, so it is decoded from state rather than registered
  assign bus.fifo_rd_en_o = (state == REQ) && !bus.fifo_empty_i;
  assign bus.m_valid_o    = valid_q;
  assign bus.m_data_o     = data_q;
  assign bus.count_o      = count_q;
  assign bus.err_o        = err_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: behavioural FIFO, expected-word queue and a forked stream monitor.
module tb_fifo_reader;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_reader_if #(.WIDTH(WIDTH)) ifc ();

  fifo_reader #(.WIDTH(WIDTH), .BURST_LEN(4), .TIMEOUT(64)) dut (
    .rd_clk_i (clk),
    .rst_i    (rst),
    .bus      (ifc)
  );

  // Behavioural FIFO: data appears the cycle after the read strobe
  logic [7:0] mem [64];
  bit         err_mem [64];
  int         push_cnt = 0;
  int         pop_cnt = 0;
  bit         hold_empty = 1'b0;
  logic [7:0] rdata = '0;
  logic       ferr = 1'b0;

  assign ifc.fifo_empty_i = hold_empty || (push_cnt == pop_cnt);
  assign ifc.fifo_rdata_i = rdata;
  assign ifc.fifo_error_i = ferr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt <= push_cnt;
      rdata   <= '0;
      ferr    <= 1'b0;
    end else begin
      ferr <= 1'b0;
      if (ifc.fifo_rd_en_o) begin
        rdata   <= mem[pop_cnt % 64];
        ferr    <= err_mem[pop_cnt % 64];
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int rd_pulses = 0;
  int done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_word(input logic [7:0] d, input bit e);
    mem[push_cnt % 64]     = d;
    err_mem[push_cnt % 64] = e;
    exp_q.push_back(d);
    push_cnt++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 ifc.start_i = 1'b1;
    @(posedge clk); #1 ifc.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifc.done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd_en"}, 32'(ifc.fifo_rd_en_o), 32'd0);
    check({name, "_valid"}, 32'(ifc.m_valid_o), 32'd0);
    check({name, "_data"},  32'(ifc.m_data_o), 32'd0);
    check({name, "_busy"},  32'(ifc.busy_o), 32'd0);
    check({name, "_done"},  32'(ifc.done_o), 32'd0);
    check({name, "_err"},   32'(ifc.err_o), 32'd0);
    check({name, "_count"}, 32'(ifc.count_o), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, r0, n;
    bit seen;
    ifc.start_i   = 1'b0;
    ifc.m_ready_i = 1'b0;

    // Stream monitor: pops the scoreboard on every handshake and checks protocol rules
    fork
      begin
        bit         pv = 1'b0;
        bit         pr = 1'b0;
        logic [7:0] pd = '0;
        forever begin
          @(negedge clk);
          cyc++;
          if (rst) begin
            pv = 1'b0;
          end else begin
            if (ifc.fifo_rd_en_o) begin
              check("rd_en_while_empty", 32'(ifc.fifo_empty_i), 32'd0);
              rd_pulses++;
              last_rd_cyc = cyc;
            end
            if (ifc.m_valid_o && !pv) check("read_latency", 32'(cyc - last_rd_cyc), 32'd2);
            if (pv && !pr) begin
              check("hold_valid", 32'(ifc.m_valid_o), 32'd1);
              check("hold_data", 32'(ifc.m_data_o), 32'(pd));
            end
            if (ifc.m_valid_o && ifc.m_ready_i) begin
              check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
              if (exp_q.size() != 0) check("beat_data", 32'(ifc.m_data_o), 32'(exp_q.pop_front()));
            end
            if (ifc.done_o) done_pulses++;
            pv = ifc.m_valid_o;
            pr = ifc.m_ready_i;
            pd = ifc.m_data_o;
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_init");
    rst = 1'b0;

    // Basic burst with downstream always ready
    push_word(8'h11, 0); push_word(8'h22, 0); push_word(8'h33, 0); push_word(8'h44, 0);
    ifc.m_ready_i = 1'b1;
    d0 = done_pulses; r0 = rd_pulses;
    pulse_start();
    wait_done(60, "t1");
    check("t1_count_at_done", 32'(ifc.count_o), 32'd4);
    check("t1_busy_at_done", 32'(ifc.busy_o), 32'd1);
    @(negedge clk);
    check("t1_busy_idle", 32'(ifc.busy_o), 32'd0);
    check("t1_done_low", 32'(ifc.done_o), 32'd0);
    check("t1_count_hold", 32'(ifc.count_o), 32'd4);
    check("t1_done_pulses", 32'(done_pulses - d0), 32'd1);
    check("t1_rd_pulses", 32'(rd_pulses - r0), 32'd4);
    check("t1_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure in SEND
    push_word(8'hA5, 0); push_word(8'h5A, 0); push_word(8'hC3, 0); push_word(8'h3C, 0);
    ifc.m_ready_i = 1'b0;
    d0 = done_pulses;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.m_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("t2_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall_valid", 32'(ifc.m_valid_o), 32'd1);
      check("t2_stall_data", 32'(ifc.m_data_o), 32'hA5);
      check("t2_stall_rd_en", 32'(ifc.fifo_rd_en_o), 32'd0);
      check("t2_stall_count", 32'(ifc.count_o), 32'd0);
    end
    @(posedge clk); #1 ifc.m_ready_i = 1'b1;
    wait_done(60, "t2");
    check("t2_count", 32'(ifc.count_o), 32'd4);
    @(negedge clk);
    check("t2_done_pulses", 32'(done_pulses - d0), 32'd1);

    // FIFO empty for a while in REQ
    hold_empty = 1'b1;
    push_word(8'h01, 0); push_word(8'h02, 0); push_word(8'h03, 0); push_word(8'h04, 0);
    r0 = rd_pulses;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_empty_rd_en", 32'(ifc.fifo_rd_en_o), 32'd0);
      check("t3_empty_busy", 32'(ifc.busy_o), 32'd1);
    end
    @(posedge clk); #1 hold_empty = 1'b0;
    wait_done(60, "t3");
    check("t3_count", 32'(ifc.count_o), 32'd4);
    check("t3_rd_pulses", 32'(rd_pulses - r0), 32'd4);

    // FIFO error during CAPT: sticky until next accepted start
    push_word(8'h61, 0); push_word(8'h62, 1); push_word(8'h63, 0); push_word(8'h64, 0);
    pulse_start();
    wait_done(60, "t4");
    check("t4_err_at_done", 32'(ifc.err_o), 32'd1);
    @(negedge clk);
    check("t4_err_idle", 32'(ifc.err_o), 32'd1);
    check("t4_busy_idle", 32'(ifc.busy_o), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 32'(ifc.err_o), 32'd1);
    push_word(8'h71, 0); push_word(8'h72, 0); push_word(8'h73, 0); push_word(8'h74, 0);
    pulse_start();
    @(negedge clk);
    check("t4_err_cleared", 32'(ifc.err_o), 32'd0);
    wait_done(60, "t4b");
    check("t4b_err", 32'(ifc.err_o), 32'd0);

    // Reset in SEND with two words delivered, then a fresh full burst
    push_word(8'h81, 0); push_word(8'h82, 0); push_word(8'h83, 0); push_word(8'h84, 0);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.m_valid_o && ifc.count_o == 8'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_send_count2_seen", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("t5_midburst_reset");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    push_word(8'h91, 0); push_word(8'h92, 0); push_word(8'h93, 0); push_word(8'h94, 0);
    d0 = done_pulses;
    pulse_start();
    wait_done(60, "t5");
    check("t5_count", 32'(ifc.count_o), 32'd4);
    @(negedge clk);
    check("t5_done_pulses", 32'(done_pulses - d0), 32'd1);
    check("t5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // FIFO permanently empty
    hold_empty = 1'b1;
    d0 = done_pulses; r0 = rd_pulses;
    pulse_start();
`ifdef FIFO_READER_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (ifc.done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_timeout_done_seen", 32'(seen), 32'd1);
    check("t6_timeout_cycles", 32'(n), 32'd65);
    check("t6_timeout_err", 32'(ifc.err_o), 32'd1);
`else
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.done_o) n++;
    end
    check("t6_no_done", 32'(n), 32'd0);
    check("t6_still_busy", 32'(ifc.busy_o), 32'd1);
    check("t6_no_err", 32'(ifc.err_o), 32'd0);
`endif
    check("t6_no_reads", 32'(rd_pulses - r0), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hold_empty = 1'b0;
    @(negedge clk);
    check("t6_after_reset_busy", 32'(ifc.busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
